move_control: RTL and testbench

Turn and cursor controller that sits directly upstream of the board storage block in the Othello datapath. It turns debounced push-button levels into cursor moves and place commands. It drives the board's `x`, `y`, `side`, `detecten`, `writeen` and `en_plot` inputs, and sequences each placement as detect → evaluate `dir` → write → swap side. It reports illegal moves and a count of successful moves.

---
 rtl/move_control.sv | 141 ++++++++++++++
 tb/tb_move_control.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_control.sv
// rtl/move_control.sv - Othello cursor/turn controller sequencing detect, evaluate, write and side swap
module move_control #(
  parameter int DET_CYCLES = 9,
  parameter int WR_CYCLES  = 9
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_place,
  input  logic [1:0] q,
  input  logic [7:0] dir,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       side,
  output logic       detecten,
  output logic       writeen,
  output logic       en_plot,
  output logic       busy,
  output logic       illegal,
  output logic [5:0] moves
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DETECT,
    S_EVAL,
    S_WRITE,
    S_SWAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       key_prev_q, key_prev_d;
  logic [2:0]       x_q, x_d, y_q, y_d;
  logic             side_q, side_d;
  logic             illegal_q, illegal_d;
  logic [5:0]       moves_q, moves_d;
  logic [4:0]       keys, edges;
  logic             unused_q0;

  // Bit order doubles as priority: place, up, down, left, right.
  assign keys      = {key_place, key_up, key_down, key_left, key_right};
  assign edges     = keys & ~key_prev_q;
  assign unused_q0 = q[0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_prev_d = keys;
    x_d        = x_q;
    y_d        = y_q;
    side_d     = side_q;
    illegal_d  = illegal_q;
    moves_d    = moves_q;
    case (state_q)
      S_IDLE: begin
        if (edges[4]) begin
          illegal_d = q[1];
          if (!q[1]) begin
            state_d = S_DETECT;
            cnt_d   = CNT_W'(DET_CYCLES - 1);
          end
        end else if (edges[3]) begin
          y_d       = y_q - 3'd1;
          illegal_d = 1'b0;
        end else if (edges[2]) begin
          y_d       = y_q + 3'd1;
          illegal_d = 1'b0;
        end else if (edges[1]) begin
          x_d       = x_q - 3'd1;
          illegal_d = 1'b0;
        end else if (edges[0]) begin
          x_d       = x_q + 3'd1;
          illegal_d = 1'b0;
        end
      end
      S_DETECT: begin
        if (cnt_q == '0) state_d = S_EVAL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_EVAL: begin
        // Both enables are low here so the board's one-shot can re-arm.
        if (dir == 8'd0) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_WRITE;
          cnt_d   = CNT_W'(WR_CYCLES - 1);
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) state_d = S_SWAP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_SWAP: begin
        side_d  = ~side_q;
        if (moves_q != 6'd60) moves_d = moves_q + 6'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      key_prev_q <= 5'b11111;
      x_q        <= 3'd0;
      y_q        <= 3'd0;
      side_q     <= 1'b0;
      illegal_q  <= 1'b0;
      moves_q    <= 6'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_prev_q <= key_prev_d;
      x_q        <= x_d;
      y_q        <= y_d;
      side_q     <= side_d;
      illegal_q  <= illegal_d;
      moves_q    <= moves_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign side     = side_q;
  assign illegal  = illegal_q;
  assign moves    = moves_q;
  assign detecten = (state_q == S_DETECT);
  assign writeen  = (state_q == S_WRITE);
  assign en_plot  = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_move_control.sv
// tb/tb_move_control.sv - directed table and sequence bench for move_control
module tb_move_control;

  logic       clock = 1'b0;
  logic       resetn;
  logic       key_up, key_down, key_left, key_right, key_place;
  logic [1:0] q;
  logic [7:0] dir;
  logic [2:0] x, y;
  logic       side, detecten, writeen, en_plot, busy, illegal;
  logic [5:0] moves;

  move_control dut (
    .clock     (clock),
    .resetn    (resetn),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .key_place (key_place),
    .q         (q),
    .dir       (dir),
    .x         (x),
    .y         (y),
    .side      (side),
    .detecten  (detecten),
    .writeen   (writeen),
    .en_plot   (en_plot),
    .busy      (busy),
    .illegal   (illegal),
    .moves     (moves)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] keys;
    logic [1:0] qv;
    logic [2:0] ex;
    logic [2:0] ey;
    logic       eill;
    logic       ebusy;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_keys(input logic [4:0] k);
    {key_place, key_up, key_down, key_left, key_right} = k;
  endtask

  task automatic add(input logic [4:0] k, input logic [1:0] qv, input logic [2:0] ex,
                     input logic [2:0] ey, input logic eill, input logic ebusy);
    vec_t v;
    v.keys = k; v.qv = qv; v.ex = ex; v.ey = ey; v.eill = eill; v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_side"}, 32'(side), 0);
    chk({tag, "_moves"}, 32'(moves), 0);
    chk({tag, "_det"}, 32'(detecten), 0);
    chk({tag, "_wr"}, 32'(writeen), 0);
    chk({tag, "_plot"}, 32'(en_plot), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ill"}, 32'(illegal), 0);
  endtask

  initial begin
    int det_n, wr_n, det_bad, wr_bad, hold_bad;

    resetn = 1'b1;
    set_keys(5'b00001);
    q   = 2'b00;
    dir = 8'h00;
    step();
    step();
    chk_reset_vals("reset");

    resetn = 1'b0;
    step();
    step();
    step();
    chk("held_key_no_fire_x", 32'(x), 0);

    // Cursor table; keys = {place, up, down, left, right}
    add(5'b00000, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
    add(5'b01000, 2'b00, 3'd0, 3'd7, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd0, 3'd7, 1'b0, 1'b0);
    add(5'b00010, 2'b00, 3'd7, 3'd7, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd7, 3'd7, 1'b0, 1'b0);
    add(5'b00101, 2'b00, 3'd7, 3'd0, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd7, 3'd0, 1'b0, 1'b0);
    add(5'b00001, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
    add(5'b00001, 2'b00, 3'd1, 3'd0, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd1, 3'd0, 1'b0, 1'b0);
    add(5'b00001, 2'b00, 3'd2, 3'd0, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd2, 3'd0, 1'b0, 1'b0);
    add(5'b00100, 2'b00, 3'd2, 3'd1, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd2, 3'd1, 1'b0, 1'b0);
    add(5'b00100, 2'b00, 3'd2, 3'd2, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd2, 3'd2, 1'b0, 1'b0);
    add(5'b00100, 2'b00, 3'd2, 3'd3, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd2, 3'd3, 1'b0, 1'b0);
    add(5'b11000, 2'b11, 3'd2, 3'd3, 1'b1, 1'b0);
    add(5'b00000, 2'b11, 3'd2, 3'd3, 1'b1, 1'b0);
    add(5'b10000, 2'b10, 3'd2, 3'd3, 1'b1, 1'b0);
    add(5'b00000, 2'b00, 3'd2, 3'd3, 1'b1, 1'b0);
    add(5'b01000, 2'b00, 3'd2, 3'd2, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd2, 3'd2, 1'b0, 1'b0);
    add(5'b00100, 2'b00, 3'd2, 3'd3, 1'b0, 1'b0);
    add(5'b00000, 2'b00, 3'd2, 3'd3, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      set_keys(vecs[i].keys);
      q = vecs[i].qv;
      step();
      chk($sformatf("vec%0d_x", i), 32'(x), 32'(vecs[i].ex));
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].ey));
      chk($sformatf("vec%0d_ill", i), 32'(illegal), 32'(vecs[i].eill));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
      chk($sformatf("vec%0d_det", i), 32'(detecten), 0);
    end

    // Legal placement at (2,3); an up press during the pass must be dropped.
    q = 2'b00;
    dir = 8'h04;
    set_keys(5'b10000);
    step();
    set_keys(5'b00000);
    det_n = 0; wr_n = 0; det_bad = 0; wr_bad = 0; hold_bad = 0;
    for (int k = 0; k < 20; k++) begin
      det_n += int'(detecten);
      wr_n  += int'(writeen);
      if (detecten !== (k < 9)) det_bad++;
      if (writeen !== (k >= 10 && k <= 18)) wr_bad++;
      if (x !== 3'd2 || y !== 3'd3 || side !== 1'b0 || busy !== 1'b1) hold_bad++;
      key_up = (k == 3);
      step();
    end
    chk("legal_det_count", 32'(det_n), 9);
    chk("legal_wr_count", 32'(wr_n), 9);
    chk("legal_det_pattern_errs", 32'(det_bad), 0);
    chk("legal_wr_pattern_errs", 32'(wr_bad), 0);
    chk("legal_hold_errs", 32'(hold_bad), 0);
    chk("legal_side", 32'(side), 1);
    chk("legal_moves", 32'(moves), 1);
    chk("legal_idle_plot", 32'(en_plot), 1);
    chk("legal_idle_busy", 32'(busy), 0);
    chk("legal_up_dropped_y", 32'(y), 3);

    // Rejected by an empty direction mask.
    dir = 8'h00;
    set_keys(5'b10000);
    step();
    set_keys(5'b00000);
    det_n = 0; wr_n = 0;
    for (int k = 0; k < 10; k++) begin
      det_n += int'(detecten);
      wr_n  += int'(writeen);
      step();
    end
    chk("dir0_det_count", 32'(det_n), 9);
    chk("dir0_wr_count", 32'(wr_n), 0);
    chk("dir0_illegal", 32'(illegal), 1);
    chk("dir0_busy", 32'(busy), 0);
    chk("dir0_side", 32'(side), 1);
    chk("dir0_moves", 32'(moves), 1);
    set_keys(5'b01000);
    step();
    set_keys(5'b00000);
    chk("dir0_up_clears_ill", 32'(illegal), 0);
    chk("dir0_up_y", 32'(y), 2);
    step();

    // Reset in the fourth WRITE cycle, with a left pulse during DETECT.
    dir = 8'h04;
    set_keys(5'b10000);
    step();
    set_keys(5'b00000);
    for (int k = 0; k < 13; k++) begin
      key_left = (k == 1);
      step();
    end
    chk("midrst_in_write", 32'(writeen), 1);
    chk("midrst_left_ignored_x", 32'(x), 2);
    resetn = 1'b1;
    step();
    chk_reset_vals("midrst");
    resetn = 1'b0;
    step();

    // Saturation: 61 legal placements from a fresh reset.
    for (int m = 1; m <= 61; m++) begin
      set_keys(5'b10000);
      step();
      set_keys(5'b00000);
      for (int k = 0; k < 20; k++) step();
      if (m == 59) chk("sat_moves59", 32'(moves), 59);
      if (m == 60) chk("sat_moves60", 32'(moves), 60);
    end
    chk("sat_moves61", 32'(moves), 60);
    chk("sat_side61", 32'(side), 1);
    chk("sat_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
